// File: rtl/ntt_flat_ctrl_pkg.sv
// Shared types and elaboration helpers for the flat NTT butterfly sequencer.
package ntt_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } ntt_state_e;

  // Widest lane count the mask helper can describe.
  localparam int unsigned MAX_D = 256;

  // Number of butterfly stages for a D-lane array.
  function automatic int unsigned logd_of(input int unsigned d);
    return $clog2(d);
  endfunction

  // Width of the stage index; never narrower than one bit.
  function automatic int unsigned sw_of(input int unsigned d);
    return (logd_of(d) > 1) ? $clog2(logd_of(d)) : 1;
  endfunction

  // Lane subtract mask: lane i subtracts when bit (LOGD-1-stage) of i is set.
  function automatic logic [MAX_D-1:0] sub_mask(input int unsigned stage,
                                                input int unsigned d);
    logic [MAX_D-1:0] m;
    int unsigned      lg;
    m  = '0;
    lg = logd_of(d);
    for (int unsigned i = 0; i < MAX_D; i++) begin
      if (i < d) m[i] = 1'(i >> (lg - 1 - stage));
    end
    return m;
  endfunction

endpackage

// File: rtl/ntt_flat_ctrl_stage_seq.sv
// Butterfly stage counter: runs up for forward frames and down for inverse
// frames, flags the final stage and registers the per-lane subtract mask.
module ntt_stage_seq
  import ntt_pkg::*;
#(
  parameter  int unsigned D    = 8,
  localparam int unsigned LOGD = logd_of(D),
  localparam int unsigned SW   = sw_of(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inv,
  input  logic          load,
  input  logic          run,
  output logic [SW-1:0] stage,
  output logic          last,
  output logic [D-1:0]  sub_vec
);

  localparam logic [SW-1:0] LAST_FWD = SW'(LOGD - 1);

  logic [SW-1:0] stage_nx;
  logic          adv;

  // Final stage is LOGD-1 going forward and 0 going inverse.
  always_comb begin
    last = run && (stage == (inv ? '0 : LAST_FWD));
  end

  // Next stage: seeded during LOAD, stepped in COMPUTE, parked at 0 otherwise.
  always_comb begin
    adv      = load | (run & ~last);
    stage_nx = '0;
    if (load) begin
      stage_nx = inv ? LAST_FWD : '0;
    end else if (run & ~last) begin
      stage_nx = inv ? stage - 1'b1 : stage + 1'b1;
    end
  end

  // Stage and mask are registered together so they line up with st_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage   <= '0;
      sub_vec <= '0;
    end else begin
      stage   <= stage_nx;
      sub_vec <= adv ? D'(sub_mask(32'(stage_nx), D)) : '0;
    end
  end

endmodule

// File: rtl/ntt_flat_ctrl.sv
// Valid/ready framed sequencer for the flat D-lane NTT butterfly array:
// accepts a vector, strobes the lane-register load, walks LOGD stages and
// holds the finished frame until the sink takes it.
module ntt_flat_ctrl
  import ntt_pkg::*;
#(
  parameter  int unsigned N  = 17,
  parameter  int unsigned D  = 8,
  localparam int unsigned SW = sw_of(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inverse,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          ld_en,
  output logic          st_en,
  output logic [SW-1:0] stage,
  output logic [D-1:0]  sub_vec,
  output logic          inv,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  if (N == 0 || D < 2 || D > MAX_D || (D & (D - 1)) != 0) begin : g_bad_cfg
    $error("ntt_flat_ctrl: N must be nonzero and D a power of two in [2, MAX_D]");
  end

  ntt_state_e state, state_nx;
  logic       last;
  logic       accept;

  // Ready depends on out_ready only, so a frame can chain straight out of DONE.
  always_comb begin
    in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    accept   = in_valid && in_ready;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (in_valid) state_nx = S_LOAD;
      S_LOAD:    state_nx = S_COMPUTE;
      S_COMPUTE: if (last) state_nx = S_DONE;
      S_DONE:    if (out_ready) state_nx = in_valid ? S_LOAD : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Strobes are decoded from the next state so they are registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_en     <= 1'b0;
      st_en     <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ld_en     <= (state_nx == S_LOAD);
      st_en     <= (state_nx == S_COMPUTE);
      out_valid <= (state_nx == S_DONE);
      busy      <= (state_nx == S_LOAD) || (state_nx == S_COMPUTE);
    end
  end

  // Frame mode is captured on accept; completed frames counted with saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (accept) inv <= in_inverse;
      if (out_valid && out_ready && (frame_cnt != '1)) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  ntt_stage_seq #(.D(D)) u_stage_seq (
    .clk     (clk),
    .rst     (rst),
    .inv     (inv),
    .load    (state == S_LOAD),
    .run     (state == S_COMPUTE),
    .stage   (stage),
    .last    (last),
    .sub_vec (sub_vec)
  );

endmodule

// File: doc/ntt_flat_ctrl.md
Name: ntt_flat_ctrl

Overview:
- Sequencer for the flat D-lane, N-bit NTT butterfly array (lane registers, per-lane PE, demux-based partner routing, psi table).
- Replaces the free-running stage counter with a valid/ready framed controller. It accepts one coefficient vector, strobes the lane-register load, then steps through log2(D) butterfly stages with per-lane add/sub selects. It holds the result valid until the consumer takes it.
- Sits between the upstream polynomial source, the datapath (which stays purely structural) and the downstream sink.

Parameters:
- N, 17, coefficient width in bits (passed through for datapath pairing; no arithmetic here).
- D, 8, lane count; power of two, D >= 2.
- LOGD, $clog2(D), number of butterfly stages (localparam).
- SW, (LOGD > 1) ? $clog2(LOGD) : 1, stage index width (localparam).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream vector on datapath input a is valid.
- in_ready  output  1  controller can accept a vector this cycle.
- in_inverse  input  1  frame mode, sampled on accept: 0 = forward NTT, 1 = inverse.
- out_valid  output  1  datapath output b holds a finished frame.
- out_ready  input  1  downstream accepts the frame.
- ld_en  output  1  lane registers capture a (selects a over PE result).
- st_en  output  1  lane registers capture PE result.
- stage  output  SW  current butterfly stage, 0..LOGD-1.
- sub_vec  output  D  per-lane PE subtract select for the current stage.
- inv  output  1  latched frame mode for twiddle table bank select.
- busy  output  1  high in LOAD or COMPUTE.
- frame_cnt  output  16  completed frames; saturates at 16'hFFFF.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0 except in_ready=1. stage=0, inv=0, frame_cnt=0. Applies immediately, including mid-frame. The partial frame is discarded, no out_valid is produced, and datapath register contents are don't-care.
- States and transitions:
  - IDLE: in_ready=1. in_valid=1 -> LOAD and latch inv<=in_inverse.
  - LOAD: exactly 1 cycle. ld_en=1, busy=1, stage=0 -> COMPUTE.
  - COMPUTE: LOGD cycles. st_en=1, busy=1, stage counts 0..LOGD-1. At stage==LOGD-1 -> DONE.
  - DONE: out_valid=1, held stable with outputs frozen until out_ready=1.
    - out_ready=1 and in_valid=1: complete the frame and go directly to LOAD, latching the new in_inverse (back-to-back, no IDLE bubble).
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: stay in DONE, in_ready=0, in_valid ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from out_ready only, never from in_valid.
- Latency: accept on edge E. ld_en is high in cycle E+1 and st_en in cycles E+2..E+1+LOGD. out_valid rises in cycle E+2+LOGD (D=8: accept->out_valid = 5 cycles).
- Throughput: one frame per LOGD+2 cycles with out_ready tied high.
- sub_vec[i] = bit (LOGD-1-stage) of lane index i while st_en=1, otherwise 0.
  - D=8: stage0 -> 8'hF0, stage1 -> 8'hCC, stage2 -> 8'hAA.
  - In inverse mode the stage order is reversed: stage runs LOGD-1..0 and sub_vec follows the emitted stage value.
- frame_cnt increments on each out_valid & out_ready handshake and saturates at 16'hFFFF; it wraps never.
- ld_en and st_en are mutually exclusive. Both are 0 in IDLE and DONE, so lane registers hold.
- D=2 boundary: LOGD=1, SW=1, COMPUTE lasts 1 cycle with stage=0 and sub_vec=2'b10.
- All outputs are registered except in_ready.

Decomposition:
- Shared package ntt_pkg:
  - state encoding (IDLE/LOAD/COMPUTE/DONE, 2 bits);
  - localparams LOGD and SW as functions of D;
  - a function sub_mask(stage, D) returning the lane subtract mask.
- One natural sub-module: ntt_stage_seq. It holds the stage counter (up or down per inv), emits the last-stage flag, and produces sub_vec from the mask function.
- The FSM, handshake and frame counter stay in the top level.

Test Plan:
- Reset then single forward frame: in_valid=1 for 1 cycle, in_inverse=0, out_ready=1 (D=8) -> ld_en at E+1; st_en E+2..E+4 with stage 0,1,2 and sub_vec F0,CC,AA; out_valid for 1 cycle at E+5; frame_cnt=1.
- Inverse frame: in_inverse=1 -> inv=1 and stage 2,1,0 with sub_vec AA,CC,F0 -> out_valid at E+5.
- Backpressure: out_ready=0 for 4 cycles in DONE, in_valid=1 throughout -> out_valid held, in_ready=0, no ld_en. On out_ready=1, the next ld_en comes the following cycle, then steady state of 5 cycles per frame.
- Back-to-back streaming: 10 frames, in_valid and out_ready tied high -> out_valid exactly every 5 cycles, frame_cnt=10, no IDLE cycles.
- Async reset mid-COMPUTE (stage=1) -> immediately in_ready=1, st_en=0, busy=0, stage=0; no spurious out_valid afterwards.
- Parameter sweep D=2 and D=32 -> LOGD stages (1 and 5), accept->out_valid latency 3 and 7; frame_cnt preloaded to FFFE via two forced frames saturates at FFFF.
